// File: rtl/id_imm_queue_pkg.sv
// Shared definitions for the decode-side immediate queue: extender select
// codes, MIPS opcode/funct constants and the decoded-field record.
package id_imm_queue_pkg;

    typedef enum logic [2:0] {
        EXTEND32_NON   = 3'b000,
        EXTEND8_Z      = 3'b001,
        EXTEND16_SL2_S = 3'b010,
        EXTEND16_S     = 3'b011,
        EXTEND5_Z      = 3'b100,
        EXTEND8_S      = 3'b101,
        EXTEND16_Z     = 3'b110,
        EXTEND_NONE    = 3'b111
    } ext_sel_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

    typedef struct packed {
        ext_sel_e    ent_sig;
        logic [4:0]  data5;
        logic [7:0]  data8;
        logic [15:0] data16;
        logic [31:0] data32;
    } imm_fields_t;

    localparam imm_fields_t FIELDS_RESET = '{
        ent_sig: EXTEND_NONE,
        data5:   5'd0,
        data8:   8'd0,
        data16:  16'd0,
        data32:  32'd0
    };

    // Jump target keeps the 256 MB region of the delay-slot address.
    function automatic logic [31:0] jump_target(input logic [31:0] instr,
                                                input logic [31:0] pc_plus4);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/id_imm_queue_decode.sv
// Combinational decode of one instruction into the extender select code
// and the raw immediate fields; fields are filled whatever the select is.
module id_imm_decode
    import id_imm_queue_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [31:0]   instr,
    input  logic [PC_W-1:0] pc,
    output imm_fields_t   fields
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [31:0] pc_plus4;
    ext_sel_e    ent_sig;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rt       = instr[20:16];
    assign pc_plus4 = 32'(pc) + 32'd4;

    // Select the extend mode from opcode/funct; all-zero word is a true nop.
    always_comb begin
        ent_sig = EXTEND_NONE;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:
                ent_sig = EXTEND16_S;
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                ent_sig = EXTEND16_Z;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                ent_sig = EXTEND16_SL2_S;
            OP_REGIMM:
                if (rt == RT_BLTZ || rt == RT_BGEZ) ent_sig = EXTEND16_SL2_S;
            OP_SPECIAL:
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
                    ent_sig = EXTEND5_Z;
            OP_J, OP_JAL:
                ent_sig = EXTEND32_NON;
            default:
                ent_sig = EXTEND_NONE;
        endcase
        if (instr == 32'd0) ent_sig = EXTEND_NONE;
    end

    assign fields.ent_sig = ent_sig;
    assign fields.data5   = instr[10:6];
    assign fields.data8   = instr[7:0];
    assign fields.data16  = instr[15:0];
    assign fields.data32  = jump_target(instr, pc_plus4);

endmodule

// File: rtl/id_imm_queue.sv
// Decode-side FIFO between fetch and the immediate extender. Instructions
// are decoded on write; the head entry drives the extender directly.
module id_imm_queue
    import id_imm_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_ent_sig,
    output logic [4:0]      out_data5,
    output logic [7:0]      out_data8,
    output logic [15:0]     out_data16,
    output logic [31:0]     out_data32,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    imm_fields_t     fields_mem [DEPTH];
    logic [31:0]     instr_mem  [DEPTH];
    logic [PC_W-1:0] pc_mem     [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    imm_fields_t      wr_fields;
    logic             push;
    logic             pop;

    id_imm_decode #(.PC_W(PC_W)) u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .fields (wr_fields)
    );

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, cleared on reset so the idle head reads as a null entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fields_mem[i] <= FIELDS_RESET;
                instr_mem[i]  <= '0;
                pc_mem[i]     <= '0;
            end
        end else if (push) begin
            fields_mem[wr_ptr] <= wr_fields;
            instr_mem[wr_ptr]  <= in_instr;
            pc_mem[wr_ptr]     <= in_pc;
        end
    end

    assign out_ent_sig = fields_mem[rd_ptr].ent_sig;
    assign out_data5   = fields_mem[rd_ptr].data5;
    assign out_data8   = fields_mem[rd_ptr].data8;
    assign out_data16  = fields_mem[rd_ptr].data16;
    assign out_data32  = fields_mem[rd_ptr].data32;
    assign out_instr   = instr_mem[rd_ptr];
    assign out_pc      = pc_mem[rd_ptr];

endmodule

// File: tb/tb_id_imm_queue.sv
// Self-checking bench for id_imm_queue: directed decode table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_id_imm_queue;
    import id_imm_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_ent_sig;
    logic [4:0]      out_data5;
    logic [7:0]      out_data8;
    logic [15:0]     out_data16;
    logic [31:0]     out_data32;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t model_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  sig;
        logic [15:0] d16;
        logic [31:0] d32;
    } vec_t;

    vec_t vecs[12];

    id_imm_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ent_sig (out_ent_sig),
        .out_data5   (out_data5),
        .out_data8   (out_data8),
        .out_data16  (out_data16),
        .out_data32  (out_data32),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written from the instruction-class rules.
    function automatic logic [2:0] modelSel(input logic [31:0] instr);
        int op, fn, rt;
        op = int'(instr >> 26);
        fn = int'(instr & 32'h3F);
        rt = int'((instr >> 16) & 32'h1F);
        if (instr == 32'd0) return EXTEND_NONE;
        if (op inside {8, 9, 10, 11, 32, 33, 35, 36, 37, 40, 41, 43}) return EXTEND16_S;
        if (op inside {12, 13, 14, 15}) return EXTEND16_Z;
        if (op inside {4, 5, 6, 7}) return EXTEND16_SL2_S;
        if (op == 1 && rt inside {0, 1}) return EXTEND16_SL2_S;
        if (op == 0 && fn inside {0, 2, 3}) return EXTEND5_Z;
        if (op inside {2, 3}) return EXTEND32_NON;
        return EXTEND_NONE;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT's visible state against the model's queue.
    task automatic compareModel();
        logic [31:0] pc4;
        entry_t      h;
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        checkOutput("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            h   = model_q[0];
            pc4 = h.pc + 32'd4;
            checkOutput("head_sig",    32'(out_ent_sig), 32'(modelSel(h.instr)));
            checkOutput("head_data5",  32'(out_data5),  (h.instr >> 6) & 32'h1F);
            checkOutput("head_data8",  32'(out_data8),  h.instr & 32'hFF);
            checkOutput("head_data16", 32'(out_data16), h.instr & 32'hFFFF);
            checkOutput("head_data32", out_data32,
                        (pc4 & 32'hF000_0000) | ((h.instr & 32'h03FF_FFFF) * 4));
            checkOutput("head_instr",  out_instr, h.instr);
            checkOutput("head_pc",     out_pc, h.pc);
        end
    endtask

    // One clock cycle: check, drive, clock, advance the model, settle.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic ordy,
                                 input logic fl);
        bit was_ready;
        bit was_valid;
        entry_t e;
        compareModel();
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        was_ready = (model_q.size() != DEPTH);
        was_valid = (model_q.size() != 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (was_valid && ordy) void'(model_q.pop_front());
            if (v && was_ready) begin
                e.instr = instr;
                e.pc    = pc;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    // Directed decode table, hand sequences, then random traffic.
    initial begin
        logic [31:0] rinstr;
        logic [31:0] rpc;
        int          sel;
        int          ops[12];

        ops = '{8, 9, 12, 13, 15, 4, 5, 1, 2, 3, 35, 43};

        vecs[0]  = '{32'h2128FFFC, 32'h00400000, EXTEND16_S,     16'hFFFC, 32'h04A3FFF0};
        vecs[1]  = '{32'h1109FFFF, 32'h00400004, EXTEND16_SL2_S, 16'hFFFF, 32'h0427FFFC};
        vecs[2]  = '{32'h3508ABCD, 32'h00400008, EXTEND16_Z,     16'hABCD, 32'h0422AF34};
        vecs[3]  = '{32'h08000010, 32'h8FFFFFFC, EXTEND32_NON,   16'h0010, 32'h90000040};
        vecs[4]  = '{32'h08000010, 32'h8FFFFFF8, EXTEND32_NON,   16'h0010, 32'h80000040};
        vecs[5]  = '{32'h0C000001, 32'hFFFFFFFC, EXTEND32_NON,   16'h0001, 32'h00000004};
        vecs[6]  = '{32'h000941C0, 32'h00000100, EXTEND5_Z,      16'h41C0, 32'h00250700};
        vecs[7]  = '{32'h00000000, 32'h00400010, EXTEND_NONE,    16'h0000, 32'h00000000};
        vecs[8]  = '{32'h3C011234, 32'h20000000, EXTEND16_Z,     16'h1234, 32'h200448D0};
        vecs[9]  = '{32'h01095020, 32'h00000000, EXTEND_NONE,    16'h5020, 32'h04254080};
        vecs[10] = '{32'h0500FFFE, 32'h00000000, EXTEND16_SL2_S, 16'hFFFE, 32'h0403FFF8};
        vecs[11] = '{32'hAD090008, 32'h00000000, EXTEND16_S,     16'h0008, 32'h04240020};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_ent_sig",   32'(out_ent_sig), 32'(EXTEND_NONE));
        checkOutput("rst_data16",    32'(out_data16), 32'd0);
        checkOutput("rst_data32",    out_data32, 32'd0);
        checkOutput("rst_pc",        out_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test-plan opener: addi visible one cycle after push, then popped.
        applyStimulus(1'b1, 32'h2128FFFC, 32'h00400000, 1'b1, 1'b0);
        checkOutput("addi_valid", 32'(out_valid), 32'd1);
        checkOutput("addi_sig",   32'(out_ent_sig), 32'(EXTEND16_S));
        checkOutput("addi_d16",   32'(out_data16), 32'h0000FFFC);
        checkOutput("addi_pc",    out_pc, 32'h00400000);
        idle(1'b1);
        checkOutput("addi_popped", 32'(out_valid), 32'd0);

        // Directed decode table: push into empty queue, check head, pop.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_sig", i), 32'(out_ent_sig), 32'(vecs[i].sig));
            checkOutput($sformatf("vec%0d_d16", i), 32'(out_data16), 32'(vecs[i].d16));
            checkOutput($sformatf("vec%0d_d32", i), out_data32, vecs[i].d32);
            if (i == 6) checkOutput("sll_data5", 32'(out_data5), 32'd7);
            idle(1'b1);
        end

        // Backpressure: beq then ori with no consumer fills the queue.
        applyStimulus(1'b1, 32'h1109FFFF, 32'h00400100, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3508ABCD, 32'h00400104, 1'b0, 1'b0);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_head_sig", 32'(out_ent_sig), 32'(EXTEND16_SL2_S));
        checkOutput("full_head_d16", 32'(out_data16), 32'h0000FFFF);
        applyStimulus(1'b1, 32'h2000_0001, 32'h00400108, 1'b1, 1'b0);
        checkOutput("ori_sig", 32'(out_ent_sig), 32'(EXTEND16_Z));
        checkOutput("ori_d16", 32'(out_data16), 32'h0000ABCD);
        idle(1'b1);
        idle(1'b1);

        // Full queue, producer and consumer both always on for 10 cycles.
        applyStimulus(1'b1, 32'h24000001, 32'h00001000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h24000002, 32'h00001004, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 32'h24000010 + 32'(i), 32'h00001008 + 32'(4 * i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with two entries queued and a same-cycle push.
        applyStimulus(1'b1, 32'h24000A01, 32'h00002000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h24000A02, 32'h00002004, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h24000A03, 32'h00002008, 1'b1, 1'b1);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready",  32'(in_ready),  32'd1);
        applyStimulus(1'b1, 32'h24000A04, 32'h0000200C, 1'b0, 1'b0);
        checkOutput("post_flush_head", out_instr, 32'h24000A04);
        idle(1'b1);
        checkOutput("post_flush_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with an entry present.
        applyStimulus(1'b1, 32'h24000B01, 32'h00003000, 1'b0, 1'b0);
        in_valid = 1'b0;
        checkOutput("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("arst_ent_sig",   32'(out_ent_sig), 32'(EXTEND_NONE));
        model_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: rinstr = $urandom;
                1: rinstr = (32'(ops[$urandom_range(0, 11)]) << 26) | ($urandom & 32'h03FF_FFFF);
                2: rinstr = ($urandom & 32'h03FF_FFC0) | 32'($urandom_range(0, 5));
                3: rinstr = 32'h0400_0000 | ($urandom & 32'h03FF_FFFF);
                default: rinstr = 32'd0;
            endcase
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(1'($urandom_range(0, 1)), rinstr, rpc,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        for (int n = 0; n < DEPTH + 2; n++) idle(1'b1);
        compareModel();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
